// File: rtl/abacus_pkg.sv
// Shared definitions for the ABACUS event counter block: register map,
// CTRL bit positions and event numbering.
package abacus_pkg;

  localparam int NUM_EVENTS = 7;

  // Word index map (wb_adr[4:0])
  localparam logic [4:0] REG_CTRL      = 5'd0;
  localparam logic [4:0] REG_STATUS    = 5'd1;
  localparam logic [4:0] REG_ID        = 5'd2;
  localparam logic [4:0] REG_CNT_FIRST = 5'd4;   // CNT0_LO
  localparam logic [4:0] REG_CNT_LAST  = 5'd17;  // CNT6_HI

  // CTRL fields
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;
  localparam int CTRL_FRZ_BIT = 2;

  typedef enum logic [2:0] {
    EV_INSN_ISSUED = 3'd0,
    EV_IC_REQ      = 3'd1,
    EV_IC_MISS     = 3'd2,
    EV_IC_FILL     = 3'd3,
    EV_DC_REQ      = 3'd4,
    EV_DC_HIT      = 3'd5,
    EV_DC_FILL     = 3'd6
  } event_e;

  function automatic logic is_cnt_idx(input logic [4:0] idx);
    return (idx >= REG_CNT_FIRST) && (idx <= REG_CNT_LAST);
  endfunction

  function automatic logic is_mapped(input logic [4:0] idx);
    return (idx <= REG_ID) || is_cnt_idx(idx);
  endfunction

endpackage

// File: rtl/abacus_counter.sv
// One free-running event counter with synchronous clear and a wrap flag
// that fires on the same edge the count rolls over to zero.
module abacus_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] value_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         bump;

  // clear beats increment, so a clearing cycle never reports a wrap
  assign bump   = en_i & inc_i & ~clr_i;
  assign wrap_o = bump & (&cnt_q);

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (bump) cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/abacus_wb_counters.sv
// Wishbone classic responder exposing the ABACUS event counters as 32-bit
// registers, with enable/freeze/clear control, sticky overflow status and
// a hi-word shadow so a LO-then-HI read pair is a consistent 64-bit sample.
module abacus_wb_counters
  import abacus_pkg::*;
#(
  parameter int          COUNTER_W       = 64,
  parameter bit          ENABLE_AT_RESET = 1'b1,
  parameter logic [31:0] BLOCK_ID        = 32'hABAC0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  input  logic [3:0]  wb_sel,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        wb_err,
  input  logic        abacus_instruction_issued,
  input  logic        abacus_icache_request,
  input  logic        abacus_icache_miss,
  input  logic        abacus_icache_line_fill_in_progress,
  input  logic        abacus_dcache_request,
  input  logic        abacus_dcache_hit,
  input  logic        abacus_dcache_line_fill_in_progress
);

  logic [NUM_EVENTS-1:0] ev;

  // gather event strobes into counter order
  always_comb begin
    ev                 = '0;
    ev[EV_INSN_ISSUED] = abacus_instruction_issued;
    ev[EV_IC_REQ]      = abacus_icache_request;
    ev[EV_IC_MISS]     = abacus_icache_miss;
    ev[EV_IC_FILL]     = abacus_icache_line_fill_in_progress;
    ev[EV_DC_REQ]      = abacus_dcache_request;
    ev[EV_DC_HIT]      = abacus_dcache_hit;
    ev[EV_DC_FILL]     = abacus_dcache_line_fill_in_progress;
  end

  // state
  logic                  ack_q, ack_d, err_q, err_d;
  logic [31:0]           dat_q, dat_d;
  logic                  enable_q, enable_d, freeze_q, freeze_d;
  logic [NUM_EVENTS-1:0] status_q, status_d;
  logic                  shadow_vld_q, shadow_vld_d;
  logic [2:0]            shadow_idx_q, shadow_idx_d;
  logic [31:0]           shadow_hi_q, shadow_hi_d;

  // decode; a request is masked while its own response is on the bus
  logic [4:0] idx, cnt_off;
  logic       req, mapped, wr, rd;
  logic       cnt_sel, cnt_hi;
  logic [2:0] cnt_k;
  logic       ctrl_wr, status_wr, clr, cnt_en;

  assign idx       = wb_adr[4:0];
  assign req       = wb_cyc & wb_stb & ~(wb_ack | wb_err);
  assign mapped    = is_mapped(idx);
  assign wr        = req & mapped & wb_we;
  assign rd        = req & mapped & ~wb_we;
  assign cnt_sel   = is_cnt_idx(idx);
  assign cnt_off   = idx - REG_CNT_FIRST;
  assign cnt_k     = cnt_off[3:1];
  assign cnt_hi    = cnt_off[0];
  assign ctrl_wr   = wr & (idx == REG_CTRL) & wb_sel[0];
  assign status_wr = wr & (idx == REG_STATUS) & wb_sel[0];
  assign clr       = ctrl_wr & wb_dat_w[CTRL_CLR_BIT];
  assign cnt_en    = enable_q & ~freeze_q;

  logic [NUM_EVENTS-1:0][COUNTER_W-1:0] cnt_val;
  logic [NUM_EVENTS-1:0]                wrap;

  for (genvar k = 0; k < NUM_EVENTS; k++) begin : g_cnt
    abacus_counter #(.W(COUNTER_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (ev[k]),
      .clr_i   (clr),
      .en_i    (cnt_en),
      .value_o (cnt_val[k]),
      .wrap_o  (wrap[k])
    );
  end

  logic [COUNTER_W-1:0] sel_cnt;

  // pick the addressed counter
  always_comb begin
    sel_cnt = '0;
    for (int k = 0; k < NUM_EVENTS; k++)
      if (cnt_k == 3'(k)) sel_cnt = cnt_val[k];
  end

  logic [31:0] rdata;

  // read mux; HI comes from the shadow only when it belongs to this counter
  always_comb begin
    rdata = '0;
    if (idx == REG_CTRL) begin
      rdata[CTRL_EN_BIT]  = enable_q;
      rdata[CTRL_FRZ_BIT] = freeze_q;
    end else if (idx == REG_STATUS) begin
      rdata[NUM_EVENTS-1:0] = status_q;
    end else if (idx == REG_ID) begin
      rdata = BLOCK_ID;
    end else if (cnt_sel) begin
      if (!cnt_hi)                                    rdata = sel_cnt[31:0];
      else if (shadow_vld_q && shadow_idx_q == cnt_k) rdata = shadow_hi_q;
      else                                            rdata = sel_cnt[COUNTER_W-1:32];
    end
  end

  // next-state for bus response, control, status and shadow
  always_comb begin
    ack_d        = req & mapped;
    err_d        = req & ~mapped;
    dat_d        = dat_q;
    enable_d     = enable_q;
    freeze_d     = freeze_q;
    status_d     = status_q;
    shadow_vld_d = shadow_vld_q;
    shadow_idx_d = shadow_idx_q;
    shadow_hi_d  = shadow_hi_q;

    if (req) dat_d = mapped ? rdata : '0;

    if (ctrl_wr) begin
      enable_d = wb_dat_w[CTRL_EN_BIT];
      freeze_d = wb_dat_w[CTRL_FRZ_BIT];
    end

    // new overflow wins over a W1C of the same bit
    if (status_wr) status_d = status_d & ~wb_dat_w[NUM_EVENTS-1:0];
    status_d = status_d | wrap;

    if (rd && cnt_sel && !cnt_hi) begin
      shadow_vld_d = 1'b1;
      shadow_idx_d = cnt_k;
      shadow_hi_d  = sel_cnt[COUNTER_W-1:32];
    end
    if (clr) shadow_vld_d = 1'b0;
  end

  // registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      dat_q        <= '0;
      enable_q     <= ENABLE_AT_RESET;
      freeze_q     <= 1'b0;
      status_q     <= '0;
      shadow_vld_q <= 1'b0;
      shadow_idx_q <= '0;
      shadow_hi_q  <= '0;
    end else begin
      ack_q        <= ack_d;
      err_q        <= err_d;
      dat_q        <= dat_d;
      enable_q     <= enable_d;
      freeze_q     <= freeze_d;
      status_q     <= status_d;
      shadow_vld_q <= shadow_vld_d;
      shadow_idx_q <= shadow_idx_d;
      shadow_hi_q  <= shadow_hi_d;
    end
  end

  assign wb_ack   = ack_q;
  assign wb_err   = err_q;
  assign wb_dat_r = dat_q;

  logic unused_bits;
  assign unused_bits = ^{wb_adr[29:5], wb_sel[3:1], wb_dat_w[31:NUM_EVENTS], cnt_off[4]};

endmodule

// File: tb/tb_abacus_wb_counters.sv
// Randomised self-checking bench for abacus_wb_counters with a
// behavioural register/counter model.
module tb_abacus_wb_counters;

  logic        clk, rst;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w, wb_dat_r;
  logic [3:0]  wb_sel;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [6:0]  ev, ev_man, ev_rnd;
  logic        rand_ev;

  int n_chk = 0;
  int n_pass = 0;

  assign ev = ev_man | ev_rnd;

  abacus_wb_counters dut (
    .clk(clk), .rst(rst), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_r(wb_dat_r),
    .wb_ack(wb_ack), .wb_err(wb_err),
    .abacus_instruction_issued(ev[0]), .abacus_icache_request(ev[1]),
    .abacus_icache_miss(ev[2]), .abacus_icache_line_fill_in_progress(ev[3]),
    .abacus_dcache_request(ev[4]), .abacus_dcache_hit(ev[5]),
    .abacus_dcache_line_fill_in_progress(ev[6])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) ev_rnd <= rand_ev ? 7'($urandom) : 7'd0;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [6:0][63:0] cnt;
    logic [6:0]       status;
    logic             en, frz, sh_valid;
    logic [2:0]       sh_idx;
    logic [31:0]      sh_hi;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(input mstate_t s);
    mstate_t    n   = s;
    logic [4:0] a   = wb_adr[4:0];
    logic       req = wb_cyc && wb_stb;
    logic       wr  = req && wb_we;
    logic       rd  = req && !wb_we;
    logic       ctl = wr && a == 5'd0 && wb_sel[0];
    logic       clr = ctl && wb_dat_w[1];
    int         k;
    if (wr && a == 5'd1 && wb_sel[0]) n.status = s.status & ~wb_dat_w[6:0];
    if (rd && a >= 5'd4 && a <= 5'd17 && !a[0]) begin
      k = (int'(a) - 4) / 2;
      n.sh_valid = 1'b1; n.sh_idx = 3'(k); n.sh_hi = s.cnt[k][63:32];
    end
    for (int j = 0; j < 7; j++) begin
      if (clr) n.cnt[j] = 64'd0;
      else if (s.en && !s.frz && ev[j]) begin
        n.cnt[j] = s.cnt[j] + 64'd1;
        if (n.cnt[j] == 64'd0) n.status[j] = 1'b1;
      end
    end
    if (clr) n.sh_valid = 1'b0;
    if (ctl) begin n.en = wb_dat_w[0]; n.frz = wb_dat_w[2]; end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{cnt: '0, status: '0, en: 1'b1, frz: 1'b0, sh_valid: 1'b0, sh_idx: '0, sh_hi: '0};
    else     m <= model_step(m);
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    int k;
    if (a == 5'd0) return {29'd0, m.frz, 1'b0, m.en};
    if (a == 5'd1) return {25'd0, m.status};
    if (a == 5'd2) return 32'hABAC0001;
    if (a >= 5'd4 && a <= 5'd17) begin
      k = (int'(a) - 4) / 2;
      if (!a[0]) return m.cnt[k][31:0];
      if (m.sh_valid && m.sh_idx == 3'(k)) return m.sh_hi;
      return m.cnt[k][63:32];
    end
    return 32'd0;
  endfunction

  // ---------------- bus driver ----------------
  logic [31:0] b_exp, b_rd;
  logic        b_ack, b_err, b_ack2, b_err2;

  task automatic bus(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    b_exp = exp_rd(a);
    wb_adr = 30'(a); wb_dat_w = d; wb_sel = s; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    b_rd = wb_dat_r; b_ack = wb_ack; b_err = wb_err;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    b_ack2 = wb_ack; b_err2 = wb_err;
  endtask

  task automatic preload(input int k, input logic [63:0] v);
    @(negedge clk);
    case (k)
      0: dut.g_cnt[0].u_cnt.cnt_q <= v;
      1: dut.g_cnt[1].u_cnt.cnt_q <= v;
      2: dut.g_cnt[2].u_cnt.cnt_q <= v;
      3: dut.g_cnt[3].u_cnt.cnt_q <= v;
      4: dut.g_cnt[4].u_cnt.cnt_q <= v;
      5: dut.g_cnt[5].u_cnt.cnt_q <= v;
      default: dut.g_cnt[6].u_cnt.cnt_q <= v;
    endcase
    m.cnt[k] <= v;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_chk++; if ({wb_ack, wb_err, wb_dat_r} !== 34'd0) $display("FAIL reset_outputs: got ack %b err %b dat %h, expected 0/0/0", wb_ack, wb_err, wb_dat_r); else n_pass++;
    @(negedge clk) rst = 1'b0;
    bus(1'b0, 5'd2, 32'd0, 4'hF);
    n_chk++; if (b_ack !== 1'b1 || b_err !== 1'b0 || b_rd !== 32'hABAC0001 || b_rd !== b_exp) $display("FAIL id_read: got ack %b dat %h, expected ack 1 dat abac0001", b_ack, b_rd); else n_pass++;
    n_chk++; if (b_ack2 !== 1'b0 || b_err2 !== 1'b0) $display("FAIL ack_one_cycle: got ack %b err %b in second cycle, expected 0/0", b_ack2, b_err2); else n_pass++;
    bus(1'b0, 5'd0, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h1 || b_rd !== b_exp) $display("FAIL ctrl_reset: got %h expected 00000001", b_rd); else n_pass++;
    bus(1'b0, 5'd1, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h0) $display("FAIL status_reset: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd3, 32'd0, 4'hF);
    n_chk++; if (b_err !== 1'b1 || b_ack !== 1'b0 || b_rd !== 32'd0 || b_err2 !== 1'b0) $display("FAIL err_idx3: got ack %b err %b dat %h, expected err 1 dat 0", b_ack, b_err, b_rd); else n_pass++;
    bus(1'b1, 5'd18, 32'h0, 4'hF);
    n_chk++; if (b_err !== 1'b1 || b_ack !== 1'b0) $display("FAIL err_idx18_write: got ack %b err %b, expected err", b_ack, b_err); else n_pass++;
  endtask

  task automatic test_count();
    repeat (10) begin @(negedge clk); ev_man[0] = 1'b1; end
    @(negedge clk); ev_man[0] = 1'b0;
    bus(1'b0, 5'd4, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd10 || b_rd !== b_exp) $display("FAIL cnt0_lo: got %0d expected 10", b_rd); else n_pass++;
    bus(1'b0, 5'd5, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0) $display("FAIL cnt0_hi: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd10, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0) $display("FAIL cnt3_lo: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd16, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0) $display("FAIL cnt6_lo: got %h expected 0", b_rd); else n_pass++;
  endtask

  task automatic test_freeze();
    bus(1'b1, 5'd0, 32'h5, 4'h1);
    bus(1'b0, 5'd0, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h5) $display("FAIL ctrl_freeze_read: got %h expected 5", b_rd); else n_pass++;
    repeat (5) begin @(negedge clk); ev_man[2] = 1'b1; end
    @(negedge clk); ev_man[2] = 1'b0;
    bus(1'b1, 5'd0, 32'h1, 4'h1);
    repeat (3) begin @(negedge clk); ev_man[2] = 1'b1; end
    @(negedge clk); ev_man[2] = 1'b0;
    bus(1'b0, 5'd8, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd3 || b_rd !== b_exp) $display("FAIL freeze_cnt2: got %0d expected 3", b_rd); else n_pass++;
  endtask

  task automatic test_wrap();
    preload(1, 64'hFFFF_FFFF_FFFF_FFFF);
    ev_man[1] = 1'b1;
    @(negedge clk); ev_man[1] = 1'b0;
    bus(1'b0, 5'd6, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0) $display("FAIL wrap_lo: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd7, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0) $display("FAIL wrap_hi: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd1, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h2 || b_rd !== b_exp) $display("FAIL wrap_status: got %h expected 2", b_rd); else n_pass++;
    bus(1'b1, 5'd1, 32'h2, 4'h1);
    bus(1'b0, 5'd1, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h0) $display("FAIL status_w1c: got %h expected 0", b_rd); else n_pass++;
  endtask

  task automatic test_shadow();
    preload(4, 64'h0000_0005_0000_0000);
    preload(0, 64'h0000_0000_FFFF_FFFE);
    ev_man[0] = 1'b1;
    bus(1'b0, 5'd4, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'hFFFF_FFFF || b_rd !== b_exp) $display("FAIL shadow_lo: got %h expected ffffffff", b_rd); else n_pass++;
    bus(1'b0, 5'd5, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0 || b_rd !== b_exp) $display("FAIL shadow_hi: got %h expected 0 (shadow)", b_rd); else n_pass++;
    bus(1'b0, 5'd13, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd5) $display("FAIL live_cnt4_hi: got %h expected 5", b_rd); else n_pass++;
    @(negedge clk); ev_man[0] = 1'b0;
    bus(1'b0, 5'd4, 32'd0, 4'hF);
    bus(1'b0, 5'd5, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd1 || b_rd !== b_exp) $display("FAIL shadow_relatch_hi: got %h expected 1", b_rd); else n_pass++;
  endtask

  task automatic test_clear();
    repeat (4) begin @(negedge clk); ev_man[5] = 1'b1; end
    @(negedge clk); ev_man[5] = 1'b0;
    fork
      bus(1'b1, 5'd0, 32'h3, 4'h1);
      begin @(negedge clk); ev_man[5] = 1'b1; @(posedge clk); #1; ev_man[5] = 1'b0; end
    join
    bus(1'b0, 5'd14, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0 || b_rd !== b_exp) $display("FAIL clear_cnt5: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd5, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0 || b_rd !== b_exp) $display("FAIL clear_shadow_hi: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd0, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h1) $display("FAIL ctrl_clr_reads0: got %h expected 1", b_rd); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    @(negedge clk);
    wb_adr = 30'd2; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; pat[i] = wb_ack; end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    n_chk++; if (pat !== 4'b0101 || wb_ack !== 1'b0) $display("FAIL back_to_back: got ack pattern %b expected 0101", pat); else n_pass++;
  endtask

  task automatic test_random();
    preload(2, 64'hFFFF_FFFF_FFFF_FFF0);
    preload(6, 64'h0000_0000_FFFF_FFF8);
    rand_ev = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int          r  = $urandom_range(0, 99);
      logic        we = (r >= 60);
      logic [4:0]  a  = 5'($urandom_range(0, 31));
      logic [31:0] d  = $urandom;
      logic [3:0]  s  = 4'($urandom) | 4'(($urandom_range(0, 3) != 0) ? 1 : 0);
      logic        mp;
      if (r >= 60 && r < 75) begin
        a = 5'd0;
        d = {29'd0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0)};
      end else if (r >= 75 && r < 90) a = 5'd1;
      mp = (a <= 5'd2) || (a >= 5'd4 && a <= 5'd17);
      bus(we, a, d, s);
      n_chk++;
      if (b_ack !== mp || b_err !== !mp || b_ack2 !== 1'b0 || b_err2 !== 1'b0 ||
          (we ? (!mp && b_rd !== 32'd0) : (b_rd !== (mp ? b_exp : 32'd0))))
        $display("FAIL random_op%0d adr %0d we %b: got ack %b err %b dat %h, expected ack %b dat %h",
                 i, a, we, b_ack, b_err, b_rd, mp, mp ? b_exp : 32'd0);
      else n_pass++;
    end
    rand_ev = 1'b0;
    repeat (2) @(negedge clk);
    bus(1'b0, 5'd1, 32'd0, 4'hF);
    n_chk++; if (b_rd !== b_exp) $display("FAIL random_status: got %h expected %h", b_rd, b_exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); ev_man[0] = 1'b1;
    repeat (3) @(negedge clk);
    ev_man[0] = 1'b0;
    wb_adr = 30'd2; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge clk); #1;
    n_chk++; if (wb_ack !== 1'b1 || wb_dat_r !== 32'hABAC0001) $display("FAIL midrst_pre: got ack %b dat %h, expected 1 abac0001", wb_ack, wb_dat_r); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({wb_ack, wb_err, wb_dat_r} !== 34'd0) $display("FAIL midrst_outputs: got ack %b err %b dat %h, expected 0/0/0", wb_ack, wb_err, wb_dat_r); else n_pass++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk); rst = 1'b0;
    bus(1'b0, 5'd4, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'd0 || b_rd !== b_exp) $display("FAIL midrst_cnt0: got %h expected 0", b_rd); else n_pass++;
    bus(1'b0, 5'd0, 32'd0, 4'hF);
    n_chk++; if (b_rd !== 32'h1) $display("FAIL midrst_ctrl: got %h expected 1", b_rd); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; rand_ev = 1'b0; ev_man = '0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    test_reset();
    test_count();
    test_freeze();
    test_wrap();
    test_shadow();
    test_clear();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded 500000 time units, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/abacus_wb_counters.md
Name: abacus_wb_counters

Overview:
Wishbone responder that sits on the bus opposite the core's idbus initiator. It counts the core's ABACUS event strobes in 64-bit counters and exposes them, with control and status registers, as 32-bit bus registers. It is instantiated beside the core wrapper in the SoC, decoded into its own address window by the interconnect. It supports only single-word classic cycles.

Parameters:
COUNTER_W, 64, counter width; fixed at 64 (lo/hi pair per counter)
ENABLE_AT_RESET, 1, reset value of CTRL.enable
BLOCK_ID, 32'hABAC0001, constant returned by the ID register

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wb_adr  in  30  word address; only bits [4:0] decoded
wb_dat_w  in  32  write data
wb_sel  in  4  byte lanes
wb_cyc  in  1  cycle valid
wb_stb  in  1  strobe
wb_we  in  1  write enable
wb_dat_r  out  32  read data, registered
wb_ack  out  1  normal termination
wb_err  out  1  error termination
abacus_instruction_issued  in  1  event 0
abacus_icache_request  in  1  event 1
abacus_icache_miss  in  1  event 2
abacus_icache_line_fill_in_progress  in  1  event 3 (cycle count)
abacus_dcache_request  in  1  event 4
abacus_dcache_hit  in  1  event 5
abacus_dcache_line_fill_in_progress  in  1  event 6 (cycle count)

Behaviour:
- Reset (async, rst=1): wb_ack=0, wb_err=0, wb_dat_r=0, all counters 0, STATUS=0, CTRL.enable=ENABLE_AT_RESET, CTRL.freeze=0, shadow_valid=0.
- Register map (word index adr[4:0]):
  - 0 CTRL (RW): bit0 enable, bit2 freeze. bit1 is clear: write-1 self-clearing, reads 0.
  - 1 STATUS (W1C): bits[6:0] sticky overflow per counter.
  - 2 ID (RO).
  - 4+2k CNTk_LO (RO), 5+2k CNTk_HI (RO), for k=0..6.
  - Indices 3 and 18..31: error.
- Bus handshake:
  - Request = cyc & stb & ~(ack|err).
  - Response is exactly one cycle after request; ack or err is high for exactly one cycle, then low.
  - Back-to-back requests therefore give at most one response per 2 cycles.
  - A request aborted (cyc dropped) before the response still completes internally; the response pulse is issued and ignored.
- Writes:
  - Honoured only for lanes with sel set (CTRL and STATUS use sel[0]).
  - Writes to RO registers are acked and ignored.
  - Unmapped index gives err with no side effects.
- Reads: wb_dat_r is valid in the ack cycle and holds its value until the next response. An err response drives 0.
- Counting, every cycle with enable=1 and freeze=0:
  - Counter k increments by 1 when event k is high.
  - Events 3 and 6 count cycles while high.
  - Events sampled while disabled or frozen are lost.
- Wrap: all-ones plus 1 gives 0 and sets STATUS[k] in the same cycle.
- Clear: a CTRL write with bit1=1 zeroes all counters on the cycle after the request, overriding any increment that cycle. STATUS is unaffected.
- Simultaneous STATUS W1C and new overflow on the same bit: set wins.
- Atomic 64-bit read:
  - Reading CNTk_LO latches counter k's hi word (same sample as lo) into shadow_hi; sets shadow_idx=k, shadow_valid=1.
  - Reading CNTk_HI returns shadow_hi when shadow_valid and shadow_idx==k, else the live hi word.
  - shadow_valid is cleared by a clear write.

Decomposition:
- Package abacus_pkg: register index localparams, CTRL bit positions, NUM_EVENTS=7, event index enum.
- Sub-module abacus_counter (one 64-bit counter: inc, clr, en inputs; value and wrap outputs), instantiated 7 times in a generate loop.

Test Plan:
- Reset, then read ID (adr 2) -> ack one cycle after stb, dat_r=32'hABAC0001; read adr 3 -> err, dat_r=0.
- Hold issued=1 for 10 cycles with enable=1; read CNT0_LO -> 10, CNT0_HI -> 0; counts 3 and 6 stay 0.
- Assert icache_miss for 5 cycles with freeze set by a CTRL write of 0x5, then write 0x1 and assert it 3 more cycles -> CNT2_LO=3.
- Force counter 1 to 64'hFFFFFFFF_FFFFFFFF (bench preload or backdoor) and pulse icache_request -> CNT1 reads 0/0, STATUS=0x02. Write STATUS=0x02 -> STATUS reads 0.
- Counter 0 at 0x0000_0000_FFFF_FFFF with issued held high: read LO (0xFFFFFFFF), then HI -> 0 from the shadow, not the live 1. A subsequent read of CNT4_HI returns live.
- CTRL write 0x3 in the same cycle as dcache_hit=1 -> CNT5=0 after the ack. Assert rst mid-transaction -> ack, err and dat_r go low immediately, counters 0.
